// File: rtl/downsample_pkg.sv
// Shared types for downsample_ctrl: Q8.8 position, FSM state and bilinear fetch order.
package downsample_pkg;

  typedef logic [23:0] pos_q8_8_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EMIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // fetch step k: bit1 selects the ceil row, bit0 the ceil column
  localparam logic [2:0] K_A4   = 3'd0;
  localparam logic [2:0] K_A3   = 3'd1;
  localparam logic [2:0] K_A2   = 3'd2;
  localparam logic [2:0] K_A1   = 3'd3;
  localparam logic [2:0] K_LAST = 3'd4;

endpackage

// File: rtl/bilinear_interpolation.sv
// Combinational bilinear blend of four neighbours with 8-bit fractional weights.
module bilinear_interpolation #(
  parameter int DW = 8
) (
  input  logic [7:0]    x,
  input  logic [7:0]    y,
  input  logic [DW-1:0] a1,
  input  logic [DW-1:0] a2,
  input  logic [DW-1:0] a3,
  input  logic [DW-1:0] a4,
  output logic [DW-1:0] result
);

  logic [8:0]     wx0, wy0;
  logic [DW+8:0]  top, bot;
  logic [DW+17:0] acc;

  // a4/a3 are the floor row, a2/a1 the ceil row; weights sum to 256 per axis
  assign wx0 = 9'd256 - {1'b0, x};
  assign wy0 = 9'd256 - {1'b0, y};
  assign top = (DW+9)'(a4) * (DW+9)'(wx0) + (DW+9)'(a3) * (DW+9)'(x);
  assign bot = (DW+9)'(a2) * (DW+9)'(wx0) + (DW+9)'(a1) * (DW+9)'(x);
  assign acc = (DW+18)'(top) * (DW+18)'(wy0) + (DW+18)'(bot) * (DW+18)'(y);
  assign result = DW'(acc >> 16);

endmodule

// File: rtl/downsample_ctrl.sv
// Bilinear downsampler sequencer: 4 SRAM reads per output pixel, then one ofmap handshake.
// Optional DOWNSAMPLE_CTRL_EDGE_CLAMP_EN clamps ceil indices to the last input row/column.
module downsample_ctrl
  import downsample_pkg::*;
#(
  parameter  int STRIDE_Q8_8 = 369,
  parameter  int HIN         = 27,
  parameter  int HOUT        = 19,
  parameter  int DW          = 8,
  localparam int AW_IN       = $clog2(HIN*HIN),
  localparam int AW_OUT      = $clog2(HOUT*HOUT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW_IN-1:0]  rd_addr,
  input  logic [DW-1:0]     rd_data,
  output logic              of_valid,
  input  logic              of_ready,
  output logic [AW_OUT-1:0] of_addr,
  output logic [DW-1:0]     of_data
);

  localparam int        IW   = (HOUT > 1) ? $clog2(HOUT) : 1;
  localparam pos_q8_8_t STEP = pos_q8_8_t'(STRIDE_Q8_8);

  state_t            state;
  logic [2:0]        k;
  logic [IW-1:0]     i, j;
  pos_q8_8_t         pos_h, pos_w;
  logic [DW-1:0]     a1, a2, a3, a4;
  logic [AW_OUT-1:0] out_idx;
  logic [15:0]       floor_h, floor_w, ceil_h_raw, ceil_w_raw, ceil_h, ceil_w, row, col;
  logic [31:0]       addr_full;
  logic              last_col, last_row;

  assign floor_h    = pos_h[23:8];
  assign floor_w    = pos_w[23:8];
  assign ceil_h_raw = floor_h + 16'd1;
  assign ceil_w_raw = floor_w + 16'd1;

`ifdef DOWNSAMPLE_CTRL_EDGE_CLAMP_EN
  assign ceil_h = (ceil_h_raw > 16'(HIN-1)) ? 16'(HIN-1) : ceil_h_raw;
  assign ceil_w = (ceil_w_raw > 16'(HIN-1)) ? 16'(HIN-1) : ceil_w_raw;
`else
  assign ceil_h = ceil_h_raw;
  assign ceil_w = ceil_w_raw;
`endif

  assign row       = k[1] ? ceil_h : floor_h;
  assign col       = k[0] ? ceil_w : floor_w;
  assign addr_full = 32'(row) * 32'(HIN) + 32'(col);

  assign rd_en    = (state == FETCH) && (k < K_LAST);
  assign rd_addr  = rd_en ? AW_IN'(addr_full) : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign of_valid = (state == EMIT);
  assign of_addr  = out_idx;
  assign last_col = (j == IW'(HOUT-1));
  assign last_row = (i == IW'(HOUT-1));

  bilinear_interpolation #(.DW(DW)) u_interp (
    .x      (pos_w[7:0]),
    .y      (pos_h[7:0]),
    .a1     (a1),
    .a2     (a2),
    .a3     (a3),
    .a4     (a4),
    .result (of_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      i       <= '0;
      j       <= '0;
      pos_h   <= '0;
      pos_w   <= '0;
      out_idx <= '0;
      a1      <= '0;
      a2      <= '0;
      a3      <= '0;
      a4      <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= FETCH;
          k       <= '0;
          i       <= '0;
          j       <= '0;
          pos_h   <= '0;
          pos_w   <= '0;
          out_idx <= '0;
        end
        FETCH: begin
          // SRAM data for step k lands one cycle later, at k+1
          case (k)
            K_A4 + 3'd1: a4 <= rd_data;
            K_A3 + 3'd1: a3 <= rd_data;
            K_A2 + 3'd1: a2 <= rd_data;
            K_A1 + 3'd1: a1 <= rd_data;
            default: ;
          endcase
          if (k == K_LAST) state <= EMIT;
          else             k     <= k + 3'd1;
        end
        EMIT: if (of_ready) begin
          k       <= '0;
          out_idx <= out_idx + AW_OUT'(1);
          if (last_col) begin
            j     <= '0;
            pos_w <= '0;
            if (last_row) begin
              state <= DONE;
            end else begin
              i     <= i + IW'(1);
              pos_h <= pos_h + STEP;
              state <= FETCH;
            end
          end else begin
            j     <= j + IW'(1);
            pos_w <= pos_w + STEP;
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_downsample_ctrl.sv
// Directed bench for downsample_ctrl; the clamp build also exercises a 4x4 -> 3x3 instance.
module tb_downsample_ctrl;

  localparam int DW = 8;
  localparam int AW_IN = 10;
  localparam int AW_OUT = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              of_ready = 1'b0;
  logic              busy, done, rd_en, of_valid;
  logic [AW_IN-1:0]  rd_addr;
  logic [DW-1:0]     rd_data;
  logic [AW_OUT-1:0] of_addr;
  logic [DW-1:0]     of_data;

  always #5 clk = ~clk;

  downsample_ctrl #(.STRIDE_Q8_8(369), .HIN(27), .HOUT(19), .DW(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .of_valid(of_valid), .of_ready(of_ready), .of_addr(of_addr), .of_data(of_data)
  );

  // ifmap[r][c] = r*27+c is the address itself, truncated to DW bits
  always @(posedge clk) if (rd_en) rd_data <= rd_addr[7:0];

  int ncmp = 0;
  int nerr = 0;
  int rd_cnt = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [AW_IN-1:0]  rd_log [2048];
  logic [AW_OUT-1:0] hs_addr [512];
  logic [DW-1:0]     hs_data [512];

  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_cnt < 2048) rd_log[rd_cnt] = rd_addr;
      rd_cnt++;
    end
    if (of_valid && of_ready) begin
      if (hs_cnt < 512) begin
        hs_addr[hs_cnt] = of_addr;
        hs_data[hs_cnt] = of_data;
      end
      hs_cnt++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    rd_cnt = 0;
    hs_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max);
    chk(tag, done, 1);
  endtask

  task automatic wait_hs(input int target, input int max, input string tag);
    int n = 0;
    while (hs_cnt < target && n < max) begin
      tick();
      n++;
    end
    chk(tag, (hs_cnt >= target), 1);
  endtask

  task automatic chk_px(input string tag, input int px, input int e0, input int e1,
                        input int e2, input int e3, input int ed);
    chk({tag, "_rd0"}, rd_log[4*px],   e0);
    chk({tag, "_rd1"}, rd_log[4*px+1], e1);
    chk({tag, "_rd2"}, rd_log[4*px+2], e2);
    chk({tag, "_rd3"}, rd_log[4*px+3], e3);
    chk({tag, "_addr"}, hs_addr[px], px);
    chk({tag, "_data"}, hs_data[px], ed);
  endtask

`ifdef DOWNSAMPLE_CTRL_EDGE_CLAMP_EN
  logic       start_c = 1'b0;
  logic       busy_c, done_c, rd_en_c, of_valid_c;
  logic [3:0] rd_addr_c, of_addr_c;
  logic [7:0] rd_data_c, of_data_c;
  int         rd_cnt_c = 0;
  int         hs_cnt_c = 0;
  logic [3:0] rd_log_c [64];
  logic [7:0] hs_data_c [16];

  downsample_ctrl #(.STRIDE_Q8_8(384), .HIN(4), .HOUT(3), .DW(8)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .of_valid(of_valid_c), .of_ready(1'b1), .of_addr(of_addr_c), .of_data(of_data_c)
  );

  always @(posedge clk) if (rd_en_c) rd_data_c <= 8'd7;

  always @(negedge clk) begin
    if (rd_en_c) begin
      if (rd_cnt_c < 64) rd_log_c[rd_cnt_c] = rd_addr_c;
      rd_cnt_c++;
    end
    if (of_valid_c) begin
      if (hs_cnt_c < 16) hs_data_c[hs_cnt_c] = of_data_c;
      hs_cnt_c++;
    end
  end
`endif

  initial begin
    logic [AW_OUT-1:0] held_addr;
    logic [DW-1:0]     held_data;
    int                viol, rd_before, n;

    rst_n = 1'b0;
    of_ready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_of_valid", of_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_of_addr", of_addr, 0);
    chk("rst_of_data", of_data, 0);
    rst_n = 1'b1;
    tick();

    // full map with backpressure at pixel 5 and a stray start while busy
    clr_mon();
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_rd_en", rd_en, 1);
    chk("start_rd_addr", rd_addr, 0);
    tick();
    pulse_start();
    wait_hs(5, 200, "wait_px4");
    of_ready = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!of_valid && n < 50);
    chk("bp_valid", of_valid, 1);
    chk("bp_addr", of_addr, 5);
    chk("bp_data", of_data, 7);
    held_addr = of_addr;
    held_data = of_data;
    rd_before = rd_cnt;
    viol = 0;
    repeat (9) begin
      @(negedge clk);
      if (!of_valid || of_addr !== held_addr || of_data !== held_data || rd_en) viol++;
    end
    chk("bp_hold", viol, 0);
    chk("bp_no_rd", rd_cnt - rd_before, 0);
    @(posedge clk);
    #1 of_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("px6_rd_en", rd_en, 1);
    chk("px6_rd_addr", rd_addr, 8);
    wait_done(5000, "run1_done");
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("busy_drop", busy, 0);
    chk("done_width", done, 0);
    repeat (5) @(negedge clk);
    chk("hs_total", hs_cnt, 361);
    chk("done_cnt", done_cnt, 1);
    chk("rd_total", rd_cnt, 1444);
    chk_px("px_1_1", 20, 28, 29, 55, 56, 40);
    chk_px("px_18_18", 360, 700, 701, 727, 728, 214);

    // reset mid-map, then a clean restart
    tick();
    clr_mon();
    pulse_start();
    wait_hs(100, 1000, "wait_px100");
    rst_n = 1'b0;
    tick();
    tick();
    chk("midrst_valid", of_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rd_en", rd_en, 0);
    rst_n = 1'b1;
    rd_before = rd_cnt;
    repeat (5) tick();
    chk("abort_no_rd", rd_cnt - rd_before, 0);
    chk("abort_no_done", done_cnt, 0);
    clr_mon();
    pulse_start();
    wait_done(5000, "run2_done");
    repeat (3) @(negedge clk);
    chk("rerun_first_addr", hs_addr[0], 0);
    chk("rerun_first_data", hs_data[0], 0);
    chk("rerun_hs_total", hs_cnt, 361);
    chk("rerun_done_cnt", done_cnt, 1);

`ifdef DOWNSAMPLE_CTRL_EDGE_CLAMP_EN
    tick();
    rd_cnt_c = 0;
    hs_cnt_c = 0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_c && n < 200);
    chk("clamp_done", done_c, 1);
    chk("clamp_hs_total", hs_cnt_c, 9);
    for (int q = 0; q < 4; q++) chk("clamp_px22_rd", rd_log_c[32+q], 15);
    chk("clamp_px22_data", hs_data_c[8], 7);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
